// File: rtl/uart_rx_leds.sv
// UART 8N1 receiver with an LED command decoder.
// Bytes of the form 3'b101_ii_bgr write {b,g,r} into LED ii. The LED outputs are active-low.
`timescale 1ns/1ps
module uart_rx_leds #(
    parameter int unsigned CLK_HZ = 100_000_000,
    parameter int unsigned BAUD   = 115200
) (
    input  logic       fpga_sysclk,
    input  logic       rst_fpga_,
    input  logic       uart_rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic [7:0] err_cnt,
    output logic [2:0] led_rgb0,
    output logic [2:0] led_rgb1,
    output logic [2:0] led_rgb2,
    output logic [2:0] led_rgb3
);

    localparam int unsigned BIT_DIV = CLK_HZ / BAUD;
    localparam int unsigned HALF    = BIT_DIV / 2;
    localparam int unsigned TW      = $clog2(BIT_DIV);

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StWaitHi} state_t;

    state_t      state;
    logic [TW-1:0] timer;
    logic [2:0]  bit_idx;
    logic [7:0]  shift;
    logic        rx_meta;
    logic        rxs;
    logic [1:0]  settle;
    logic        armed;
    logic [11:0] led_state;

    wire expired = (timer == '0);
    wire settled = (settle == 2'd2);

    // Two-flop synchronizer preset high, plus a counter marking when rxs reflects the real line.
    always_ff @(posedge fpga_sysclk or negedge rst_fpga_) begin
        if (!rst_fpga_) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            settle  <= 2'd0;
        end else begin
            rx_meta <= uart_rxd;
            rxs     <= rx_meta;
            if (!settled) settle <= settle + 2'd1;
        end
    end

    // Receive FSM. 'armed' means the line has been seen high, so the next low is a true 1->0 edge;
    // this keeps a line held low across reset release from starting a frame.
    always_ff @(posedge fpga_sysclk or negedge rst_fpga_) begin
        if (!rst_fpga_) begin
            state     <= StIdle;
            timer     <= '0;
            bit_idx   <= 3'd0;
            shift     <= 8'h00;
            armed     <= 1'b0;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            err_cnt   <= 8'h00;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (!armed) begin
                        armed <= settled && rxs;
                    end else if (!rxs) begin
                        state <= StStart;
                        timer <= TW'(HALF - 1);
                        armed <= 1'b0;
                    end
                end
                StStart: begin
                    if (!expired) begin
                        timer <= timer - 1'b1;
                    end else if (rxs) begin
                        // Glitch shorter than half a bit: drop it silently.
                        state <= StIdle;
                        timer <= TW'(BIT_DIV - 1);
                        armed <= 1'b1;
                    end else begin
                        state   <= StData;
                        timer   <= TW'(BIT_DIV - 1);
                        bit_idx <= 3'd0;
                    end
                end
                StData: begin
                    if (!expired) begin
                        timer <= timer - 1'b1;
                    end else begin
                        shift <= {rxs, shift[7:1]};
                        timer <= TW'(BIT_DIV - 1);
                        if (bit_idx == 3'd7) state <= StStop;
                        else                 bit_idx <= bit_idx + 3'd1;
                    end
                end
                StStop: begin
                    if (!expired) begin
                        timer <= timer - 1'b1;
                    end else begin
                        timer <= TW'(BIT_DIV - 1);
                        if (rxs) begin
                            rx_data  <= shift;
                            rx_valid <= 1'b1;
                            armed    <= 1'b1;
                            state    <= StIdle;
                        end else begin
                            frame_err <= 1'b1;
                            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                            state <= StWaitHi;
                        end
                    end
                end
                StWaitHi: begin
                    if (rxs) begin
                        state <= StIdle;
                        timer <= TW'(BIT_DIV - 1);
                        armed <= 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    // LED command decode on each good byte.
    always_ff @(posedge fpga_sysclk or negedge rst_fpga_) begin
        if (!rst_fpga_) begin
            led_state <= 12'h000;
        end else if (rx_valid && rx_data[7:5] == 3'b101) begin
            led_state[3 * rx_data[4:3] +: 3] <= rx_data[2:0];
        end
    end

    assign led_rgb0 = ~led_state[2:0];
    assign led_rgb1 = ~led_state[5:3];
    assign led_rgb2 = ~led_state[8:6];
    assign led_rgb3 = ~led_state[11:9];

endmodule

// File: tb/tb_uart_rx_leds.sv
// Scoreboard bench for uart_rx_leds: a line driver serialises bytes, a monitor checks DUT strobes.
`timescale 1ns/1ps
module tb_uart_rx_leds;

    localparam int unsigned CLK_HZ  = 100_000_000;
    localparam int unsigned BAUD    = 6_250_000;
    localparam int unsigned BIT_DIV = CLK_HZ / BAUD;
    localparam int unsigned HALF    = BIT_DIV / 2;
    localparam real         BIT_NS  = 1.0e9 / BAUD;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rxd = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic [7:0] err_cnt;
    logic [2:0] led0, led1, led2, led3;

    uart_rx_leds #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
        .fpga_sysclk(clk),
        .rst_fpga_  (rst_n),
        .uart_rxd   (rxd),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .frame_err  (frame_err),
        .err_cnt    (err_cnt),
        .led_rgb0   (led0),
        .led_rgb1   (led1),
        .led_rgb2   (led2),
        .led_rgb3   (led3)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       err;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         failures = 0;
    logic [2:0] led_model[4];
    logic [7:0] err_model;
    logic [7:0] last_good;
    logic       prev_pulse = 1'b0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) led_model[i] = 3'b000;
        err_model = 8'h00;
        last_good = 8'h00;
    endtask

    task automatic expect_byte(input logic [7:0] b);
        exp_q.push_back('{err: 1'b0, data: b});
        last_good = b;
        if (b[7:5] == 3'b101) led_model[b[4:3]] = b[2:0];
    endtask

    task automatic expect_err();
        exp_q.push_back('{err: 1'b1, data: last_good});
        if (err_model != 8'hFF) err_model = err_model + 8'd1;
    endtask

    // Serialise one frame: start, 8 data bits LSB first, stop bit of the given level.
    task automatic send_frame(input logic [7:0] b, input logic stop, input real bit_ns);
        rxd = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            #(bit_ns);
        end
        rxd = stop;
        #(bit_ns);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 4000) begin
            @(posedge clk);
            n++;
        end
        chk({name, "_drain"}, 8'(exp_q.size()), 8'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_state(input string name);
        chk({name, "_led0"}, {5'b0, led0}, {5'b0, ~led_model[0]});
        chk({name, "_led1"}, {5'b0, led1}, {5'b0, ~led_model[1]});
        chk({name, "_led2"}, {5'b0, led2}, {5'b0, ~led_model[2]});
        chk({name, "_led3"}, {5'b0, led3}, {5'b0, ~led_model[3]});
        chk({name, "_err_cnt"}, err_cnt, err_model);
    endtask

    // Monitor: every strobe pops one expected event from the scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_pulse = 1'b0;
        end else begin
            if (rx_valid || frame_err) begin
                chk("valid_and_err_together", {7'b0, rx_valid & frame_err}, 8'd0);
                chk("pulse_two_cycles", {7'b0, prev_pulse}, 8'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_strobe actual valid=%b err=%b data=%h required none",
                             rx_valid, frame_err, rx_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("strobe_kind", {7'b0, frame_err}, {7'b0, e.err});
                    chk("rx_data", rx_data, e.data);
                end
            end
            prev_pulse = rx_valid || frame_err;
        end
    end

    initial begin
        logic [7:0] b;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_rx_data", rx_data, 8'h00);
        chk("reset_rx_valid", {7'b0, rx_valid}, 8'd0);
        chk("reset_frame_err", {7'b0, frame_err}, 8'd0);
        check_state("reset");
        rst_n = 1'b1;
        repeat (6) @(negedge clk);

        // Single command byte, then a non-command byte and an all-on command.
        expect_byte(8'hA5);
        send_frame(8'hA5, 1'b1, BIT_NS);
        wait_drain("t1");
        check_state("t1");
        expect_byte(8'h55);
        send_frame(8'h55, 1'b1, BIT_NS);
        wait_drain("t2a");
        check_state("t2a");
        expect_byte(8'hBF);
        send_frame(8'hBF, 1'b1, BIT_NS);
        wait_drain("t2b");
        check_state("t2b");

        // Stop bit low with the line held low (break), then recovery.
        expect_err();
        send_frame(8'h3C, 1'b0, BIT_NS);
        #(3.0 * BIT_NS);
        rxd = 1'b1;
        #(2.0 * BIT_NS);
        wait_drain("t3_err");
        check_state("t3_err");
        expect_byte(8'hA9);
        send_frame(8'hA9, 1'b1, BIT_NS);
        wait_drain("t3");
        check_state("t3");

        // Short low glitch must not produce any strobe.
        @(posedge clk);
        rxd = 1'b0;
        repeat (HALF - 3) @(posedge clk);
        rxd = 1'b1;
        repeat (4 * BIT_DIV) @(posedge clk);
        wait_drain("t4");
        check_state("t4");

        // Random bytes with random idle gaps at the nominal rate.
        for (int k = 0; k < 8; k++) begin
            b = 8'($urandom);
            if ($urandom_range(0, 1) == 1) b[7:5] = 3'b101;
            expect_byte(b);
            send_frame(b, 1'b1, BIT_NS);
            repeat ($urandom_range(0, 40)) @(posedge clk);
        end
        wait_drain("rand");
        check_state("rand");

        // Ten back-to-back frames at +2% and -2% line rate.
        for (int r = 0; r < 2; r++) begin
            real bit_ns;
            bit_ns = (r == 0) ? BIT_NS / 1.02 : BIT_NS / 0.98;
            for (int k = 0; k < 10; k++) begin
                b = 8'($urandom);
                if ($urandom_range(0, 2) == 0) b[7:5] = 3'b101;
                expect_byte(b);
                send_frame(b, 1'b1, bit_ns);
            end
            wait_drain(r == 0 ? "fast" : "slow");
            check_state(r == 0 ? "fast" : "slow");
        end

        // Reset during bit 4 of a frame; released while the line is high in bit 7.
        fork
            send_frame(8'hA5, 1'b1, BIT_NS);
            begin
                #(5.5 * BIT_NS);
                rst_n = 1'b0;
                #1;
                model_reset();
                chk("midreset_rx_data", rx_data, 8'h00);
                chk("midreset_rx_valid", {7'b0, rx_valid}, 8'd0);
                check_state("midreset");
                #(3.0 * BIT_NS);
                rst_n = 1'b1;
            end
        join
        repeat (3 * BIT_DIV) @(posedge clk);
        wait_drain("t6_quiet");
        expect_byte(8'hB7);
        send_frame(8'hB7, 1'b1, BIT_NS);
        wait_drain("t6");
        check_state("t6");
        chk("t6_rx_data", rx_data, 8'hB7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
